eth_frame_tx: RTL and testbench

- Transmit-side framer that builds the byte-serial Ethernet-style frames consumed by the receive block.
- Accepts a send request (destination MAC, payload length) and buffers the payload bytes from an upstream valid/ready source.
- Once the whole payload is buffered and the link is ready, emits one gap-free frame at one byte per clk: preamble, SFD, dst MAC, src MAC, length, payload, 4-byte LRC FCS.

---
 rtl/eth_pkg.sv | 35 +++
 rtl/eth_frame_tx_if.sv | 28 ++
 rtl/byte_fifo.sv | 37 +++
 rtl/eth_frame_tx.sv | 136 +++++++++++++
 tb/tb_eth_frame_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet-style framing constants and types, common to the transmit and receive blocks.
package eth_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'hAA;
  localparam logic [7:0] SFD_BYTE      = 8'hAB;

  localparam int PREAMBLE_LEN = 7;
  localparam int MAC_LEN      = 6;
  localparam int LEN_LEN      = 2;
  localparam int FCS_LEN      = 4;

  typedef logic [47:0] mac_addr_t;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT, S_PREAMBLE, S_SFD, S_MACDST,
    S_MACSRC, S_PLLEN, S_PL, S_FCS, S_DONE
  } tx_state_t;

  // MAC addresses go on the wire low byte first.
  function automatic logic [7:0] mac_byte(mac_addr_t mac, logic [2:0] idx);
    return mac[{idx, 3'b000} +: 8];
  endfunction

  function automatic tx_state_t next_field(tx_state_t s);
    case (s)
      S_PREAMBLE: return S_SFD;
      S_SFD:      return S_MACDST;
      S_MACDST:   return S_MACSRC;
      S_MACSRC:   return S_PLLEN;
      S_PLLEN:    return S_PL;
      S_PL:       return S_FCS;
      S_FCS:      return S_DONE;
      default:    return S_IDLE;
    endcase
  endfunction
endpackage

// File: rtl/eth_frame_tx_if.sv
// Request, payload and transmit-side signals of the frame transmitter.
interface eth_frame_tx_if;
  import eth_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_len;
  mac_addr_t   req_dst_mac;
  logic        req_err;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_ready;
  logic        link_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;

  modport master (
    output req_valid, req_len, req_dst_mac, pl_data, pl_valid, link_ready,
    input  req_ready, req_err, pl_ready, tx_data, tx_start, tx_busy, tx_done
  );

  modport slave (
    input  req_valid, req_len, req_dst_mac, pl_data, pl_valid, link_ready,
    output req_ready, req_err, pl_ready, tx_data, tx_start, tx_busy, tx_done
  );
endinterface

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO; combinational read of the head entry, pointers wrap modulo DEPTH.
module byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/eth_frame_tx.sv
// Frame transmitter: buffers a payload, then emits preamble/SFD/MACs/length/payload/LRC gap-free.
module eth_frame_tx
  import eth_pkg::*;
#(
  parameter mac_addr_t SRC_MAC_ADDR = 48'h00_0a_95_9d_68_20,
  parameter int        FIFO_DEPTH   = 64
) (
  input logic           clk,
  input logic           rst,
  eth_frame_tx_if.slave bus
);
  tx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt, field_len, len;
  mac_addr_t   dst;
  logic [7:0]  lrc, byte_nxt, fifo_rd_data;
  logic        bad_len, accept, pl_ready, wr_en, rd_en, fifo_full, fifo_empty;
  logic [7:0]  tx_data;
  logic        tx_start, tx_busy, tx_done, req_err;

  assign bad_len  = (bus.req_len == 16'd0) || (bus.req_len > 16'(FIFO_DEPTH));
  assign accept   = (state == S_IDLE) && bus.req_valid;
  assign pl_ready = (state == S_LOAD) && !fifo_full;
  assign wr_en    = pl_ready && bus.pl_valid;
  assign rd_en    = (state_nxt == S_PL) && !fifo_empty;

  assign bus.req_ready = (state == S_IDLE);
  assign bus.pl_ready  = pl_ready;
  assign bus.tx_data   = tx_data;
  assign bus.tx_start  = tx_start;
  assign bus.tx_busy   = tx_busy;
  assign bus.tx_done   = tx_done;
  assign bus.req_err   = req_err;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (bus.pl_data),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    field_len = 16'd1;
    unique case (state)
      S_PREAMBLE:         field_len = 16'(PREAMBLE_LEN);
      S_MACDST, S_MACSRC: field_len = 16'(MAC_LEN);
      S_PLLEN:            field_len = 16'(LEN_LEN);
      S_PL:               field_len = len;
      S_FCS:              field_len = 16'(FCS_LEN);
      default:            field_len = 16'd1;
    endcase
    unique case (state)
      S_IDLE: if (accept && !bad_len) begin
        state_nxt = S_LOAD;
        cnt_nxt   = '0;
      end
      S_LOAD: if (wr_en) begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == len - 16'd1) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end
      end
      S_WAIT: if (bus.link_ready) begin
        state_nxt = S_PREAMBLE;
        cnt_nxt   = '0;
      end
      S_PREAMBLE, S_SFD, S_MACDST, S_MACSRC, S_PLLEN, S_PL, S_FCS: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == field_len - 16'd1) begin
          state_nxt = next_field(state);
          cnt_nxt   = '0;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte for the upcoming cycle, chosen from the next state so tx_data can be registered.
  always_comb begin
    byte_nxt = 8'h00;
    unique case (state_nxt)
      S_PREAMBLE: byte_nxt = PREAMBLE_BYTE;
      S_SFD:      byte_nxt = SFD_BYTE;
      S_MACDST:   byte_nxt = mac_byte(dst, cnt_nxt[2:0]);
      S_MACSRC:   byte_nxt = mac_byte(SRC_MAC_ADDR, cnt_nxt[2:0]);
      S_PLLEN:    byte_nxt = cnt_nxt[0] ? len[15:8] : len[7:0];
      S_PL:       byte_nxt = fifo_rd_data;
      S_FCS:      byte_nxt = ~lrc + 8'd1;
      default:    byte_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len      <= '0;
      dst      <= '0;
      lrc      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      req_err  <= 1'b0;
    end else begin
      req_err <= accept && bad_len;
      if (accept && !bad_len) begin
        len <= bus.req_len;
        dst <= bus.req_dst_mac;
        lrc <= '0;
      end else if (state_nxt inside {S_MACDST, S_MACSRC, S_PLLEN, S_PL}) begin
        lrc <= lrc + byte_nxt;
      end
      tx_data  <= byte_nxt;
      tx_start <= (state_nxt == S_PREAMBLE) && (state != S_PREAMBLE);
      tx_busy  <= state_nxt inside {S_LOAD, S_WAIT, S_PREAMBLE, S_SFD, S_MACDST,
                                    S_MACSRC, S_PLLEN, S_PL, S_FCS};
      tx_done  <= (state_nxt == S_DONE);
    end
  end
endmodule

// File: tb/tb_eth_frame_tx.sv
// Scoreboard bench: stimulus pushes expected frames built from the framing rules; a monitor compares.
module tb_eth_frame_tx;
  import eth_pkg::*;

  localparam mac_addr_t SRC   = 48'h00_0a_95_9d_68_20;
  localparam int        DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  eth_frame_tx_if bus();

  eth_frame_tx #(.SRC_MAC_ADDR(SRC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         len_q[$];
  int         err_q[$];
  bit         in_frame = 1'b0;
  bit         done_pending = 1'b0;
  int         n_exp = 0;
  int         k_byte = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame straight from the field layout; the LRC is a plain byte sum.
  task automatic expect_frame(input mac_addr_t dst, input logic [7:0] pl[$]);
    logic [7:0]  f[$];
    logic [7:0]  sum;
    logic [15:0] len;
    sum = 8'h00;
    len = 16'(pl.size());
    repeat (7) f.push_back(8'hAA);
    f.push_back(8'hAB);
    for (int i = 0; i < 6; i++) f.push_back(dst[8*i +: 8]);
    for (int i = 0; i < 6; i++) f.push_back(SRC[8*i +: 8]);
    f.push_back(len[7:0]);
    f.push_back(len[15:8]);
    foreach (pl[i]) f.push_back(pl[i]);
    for (int i = 8; i < f.size(); i++) sum = sum + f[i];
    repeat (4) f.push_back(8'h00 - sum);
    foreach (f[i]) exp_q.push_back(f[i]);
    len_q.push_back(f.size());
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (in_frame) repeat (n_exp - k_byte) void'(exp_q.pop_front());
      in_frame     = 1'b0;
      done_pending = 1'b0;
    end else begin
      if (bus.req_err) begin
        check("req_err_expected", 32'(err_q.size() > 0), 32'd1);
        if (err_q.size() > 0) void'(err_q.pop_front());
      end
      if (!in_frame && bus.tx_start) begin
        check("frame_expected", 32'(len_q.size() > 0), 32'd1);
        if (len_q.size() > 0) begin
          n_exp    = len_q.pop_front();
          k_byte   = 0;
          in_frame = 1'b1;
        end
      end
      if (in_frame) begin
        check("frame_byte", {bus.tx_busy, bus.tx_start, bus.tx_done, bus.tx_data},
              {1'b1, k_byte == 0, 1'b0, exp_q.pop_front()});
        k_byte++;
        if (k_byte == n_exp) begin
          in_frame     = 1'b0;
          done_pending = 1'b1;
        end
      end else if (done_pending) begin
        check("done_cycle", {bus.tx_busy, bus.tx_start, bus.tx_done, bus.tx_data},
              {1'b0, 1'b0, 1'b1, 8'h00});
        done_pending = 1'b0;
      end else begin
        check("idle_quiet", {bus.tx_start, bus.tx_done, bus.tx_data}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input mac_addr_t dst, input logic [15:0] len);
    bit ok = 1'b0;
    bus.req_valid   = 1'b1;
    bus.req_len     = len;
    bus.req_dst_mac = dst;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    check("req_handshake", 32'(ok), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  // gap: 0 none, 1 idle before every odd byte (toggled valid), 2 random idles.
  task automatic feed_payload(input logic [7:0] pl[$], input int gap);
    bit ok;
    foreach (pl[i]) begin
      if ((gap == 1 && i % 2 == 1) || (gap == 2 && $urandom_range(0, 1) == 1)) begin
        bus.pl_valid = 1'b0;
        tick();
      end
      bus.pl_valid = 1'b1;
      bus.pl_data  = pl[i];
      ok = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (bus.pl_ready) begin ok = 1'b1; break; end
      end
      check("pl_handshake", 32'(ok), 32'd1);
      tick();
    end
    bus.pl_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bus.tx_done) begin ok = 1'b1; break; end
    end
    check("tx_done_seen", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic run_frame(input mac_addr_t dst, input logic [7:0] pl[$], input int gap,
                           input int link_delay, input bit drop);
    expect_frame(dst, pl);
    bus.link_ready = (link_delay == 0);
    send_req(dst, 16'(pl.size()));
    feed_payload(pl, gap);
    if (link_delay > 0) begin
      repeat (link_delay) begin
        @(negedge clk);
        check("gated_quiet", {bus.tx_start, bus.tx_data, bus.tx_busy}, {1'b0, 8'h00, 1'b1});
      end
      tick();
      bus.link_ready = 1'b1;
    end
    tick();
    tick();
    if (drop) bus.link_ready = 1'b0;
    wait_done();
  endtask

  task automatic illegal(input logic [15:0] len);
    err_q.push_back(1);
    send_req(48'h1122_3344_5566, len);
    repeat (3) begin
      @(negedge clk);
      check("illegal_idle", {bus.tx_busy, bus.req_ready}, {1'b0, 1'b1});
    end
    tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pl[$];
    bit         ok;
    bus.req_valid   = 1'b0;
    bus.req_len     = '0;
    bus.req_dst_mac = '0;
    bus.pl_valid    = 1'b0;
    bus.pl_data     = '0;
    bus.link_ready  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_values", {bus.tx_data, bus.tx_start, bus.tx_busy, bus.tx_done,
                           bus.req_err, bus.req_ready, bus.pl_ready},
          {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tick();
    rst = 1'b0;
    tick();

    pl = '{8'h01, 8'h02, 8'h03};
    run_frame(48'h00_0a_95_9d_68_16, pl, 0, 0, 1'b0);

    illegal(16'd0);
    illegal(16'd65);

    pl.delete();
    repeat (6) pl.push_back(8'($urandom));
    run_frame(48'hA1_B2_C3_D4_E5_F6, pl, 1, 10, 1'b0);

    pl.delete();
    repeat (64) pl.push_back(8'hFF);
    run_frame(48'hFF_FF_FF_FF_FF_FF, pl, 0, 0, 1'b1);

    for (int f = 0; f < 6; f++) begin
      logic [31:0] lo;
      logic [15:0] hi;
      int          n;
      lo = $urandom;
      hi = 16'($urandom);
      n  = $urandom_range(1, 64);
      pl.delete();
      repeat (n) pl.push_back(8'($urandom));
      run_frame({hi, lo}, pl, 2, $urandom_range(0, 5), bit'($urandom_range(0, 1)));
    end

    // Abandon a frame partway through its payload.
    pl.delete();
    repeat (40) pl.push_back(8'($urandom));
    expect_frame(48'h0102_0304_0506, pl);
    bus.link_ready = 1'b1;
    send_req(48'h0102_0304_0506, 16'd40);
    feed_payload(pl, 0);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.tx_start) begin ok = 1'b1; break; end
    end
    check("abort_frame_started", 32'(ok), 32'd1);
    repeat (23) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_frame_reset", {bus.tx_data, bus.tx_busy, bus.req_ready, bus.tx_start, bus.pl_ready},
          {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    tick();

    pl = '{8'h5A};
    run_frame(48'h00_0a_95_9d_68_16, pl, 0, 0, 1'b0);

    repeat (5) tick();
    check("exp_bytes_drained", 32'(exp_q.size()), 32'd0);
    check("frames_drained", 32'(len_q.size()), 32'd0);
    check("errs_drained", 32'(err_q.size()), 32'd0);
    check("not_in_frame", 32'(in_frame), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
